// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding, flush and stall counter
module id_ex_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dec_valid,
  output logic         dec_ready,
  input  logic [4:0]   dec_rs1_addr,
  input  logic [4:0]   dec_rs2_addr,
  input  logic [4:0]   dec_rd_addr,
  input  logic [N-1:0] dec_rs1_data,
  input  logic [N-1:0] dec_rs2_data,
  input  logic [N-1:0] dec_imm,
  input  logic         dec_use_imm,
  input  logic [3:0]   dec_alu_op,
  input  logic         dec_reg_write,
  input  logic         flush,
  input  logic [4:0]   exmem_rd,
  input  logic         exmem_reg_write,
  input  logic [N-1:0] exmem_data,
  input  logic [4:0]   memwb_rd,
  input  logic         memwb_reg_write,
  input  logic [N-1:0] memwb_data,
  input  logic         ex_ready,
  output logic         ex_valid,
  output logic [N-1:0] read_data_1,
  output logic [N-1:0] read_data_2,
  output logic [3:0]   OpCode,
  output logic [4:0]   ex_rd_addr,
  output logic         ex_reg_write,
  output logic [31:0]  stall_cycles
);

  logic         r_valid;
  logic [4:0]   r_rs1_addr;
  logic [4:0]   r_rs2_addr;
  logic [4:0]   r_rd_addr;
  logic [N-1:0] r_rs1_data;
  logic [N-1:0] r_rs2_data;
  logic [N-1:0] r_imm;
  logic         r_use_imm;
  logic [3:0]   r_alu_op;
  logic         r_reg_write;
  logic [31:0]  r_stall_cycles;

  logic         w_load;
  logic         w_xfer;
  logic         w_hold;
  logic         w_stall;
  logic [N-1:0] w_fwd1;
  logic [N-1:0] w_fwd2;

  assign dec_ready = !r_valid || ex_ready;
  assign w_load    = dec_valid && dec_ready;
  assign w_xfer    = r_valid && ex_ready;
  assign w_stall   = r_valid && !ex_ready;
  assign w_hold    = w_stall && !flush;

  // EX/MEM is the younger producer, so it is checked first; x0 is never forwarded.
  always_comb begin
    w_fwd1 = r_rs1_data;
    if (exmem_reg_write && (exmem_rd == r_rs1_addr) && (r_rs1_addr != 5'd0))
      w_fwd1 = exmem_data;
    else if (memwb_reg_write && (memwb_rd == r_rs1_addr) && (r_rs1_addr != 5'd0))
      w_fwd1 = memwb_data;
  end

  always_comb begin
    w_fwd2 = r_rs2_data;
    if (exmem_reg_write && (exmem_rd == r_rs2_addr) && (r_rs2_addr != 5'd0))
      w_fwd2 = exmem_data;
    else if (memwb_reg_write && (memwb_rd == r_rs2_addr) && (r_rs2_addr != 5'd0))
      w_fwd2 = memwb_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_rs1_addr  <= 5'd0;
      r_rs2_addr  <= 5'd0;
      r_rd_addr   <= 5'd0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_alu_op    <= 4'd0;
      r_reg_write <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid     <= 1'b1;
      r_rs1_addr  <= dec_rs1_addr;
      r_rs2_addr  <= dec_rs2_addr;
      r_rd_addr   <= dec_rd_addr;
      r_rs1_data  <= dec_rs1_data;
      r_rs2_data  <= dec_rs2_data;
      r_imm       <= dec_imm;
      r_use_imm   <= dec_use_imm;
      r_alu_op    <= dec_alu_op;
      r_reg_write <= dec_reg_write;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end else if (w_hold) begin
      // Capture forwarded values so a producer retiring past MEM/WB is not lost.
      r_rs1_data <= w_fwd1;
      r_rs2_data <= w_fwd2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_stall_cycles <= 32'd0;
    else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign ex_valid     = r_valid;
  assign read_data_1  = w_fwd1;
  assign read_data_2  = r_use_imm ? r_imm : w_fwd2;
  assign OpCode       = r_alu_op;
  assign ex_rd_addr   = r_rd_addr;
  assign ex_reg_write = r_valid && r_reg_write;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic [31:0] dec_rs1_data, dec_rs2_data, dec_imm;
  logic        dec_use_imm;
  logic [3:0]  dec_alu_op;
  logic        dec_reg_write;
  logic        flush;
  logic [4:0]  exmem_rd;
  logic        exmem_reg_write;
  logic [31:0] exmem_data;
  logic [4:0]  memwb_rd;
  logic        memwb_reg_write;
  logic [31:0] memwb_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] read_data_1, read_data_2;
  logic [3:0]  OpCode;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd_addr(dec_rd_addr),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm),
    .dec_use_imm(dec_use_imm), .dec_alu_op(dec_alu_op), .dec_reg_write(dec_reg_write),
    .flush(flush),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_data(exmem_data),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .OpCode(OpCode),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .stall_cycles(stall_cycles)
  );

  task automatic idle_inputs();
    dec_valid = 0; dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rd_addr = 0;
    dec_rs1_data = 0; dec_rs2_data = 0; dec_imm = 0; dec_use_imm = 0;
    dec_alu_op = 0; dec_reg_write = 0; flush = 0;
    exmem_rd = 0; exmem_reg_write = 0; exmem_data = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_data = 0;
    ex_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic set_dec(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [4:0] rd, input logic [31:0] imm,
                         input logic use_imm, input logic [3:0] op, input logic wr);
    dec_valid = 1; dec_rs1_addr = rs1; dec_rs1_data = d1;
    dec_rs2_addr = rs2; dec_rs2_data = d2; dec_rd_addr = rd;
    dec_imm = imm; dec_use_imm = use_imm; dec_alu_op = op; dec_reg_write = wr;
  endtask

  task automatic test_reset();
    idle_inputs();
    dec_valid = 1; dec_rs1_data = 32'hDEAD_BEEF; dec_alu_op = 4'hA; dec_reg_write = 1;
    rst_n = 0;
    @(posedge clk); #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall got=%h exp=0", stall_cycles); end
    total++; if (read_data_1 !== 32'd0) begin bad++; $display("FAIL reset_rd1 got=%h exp=0", read_data_1); end
    total++; if (read_data_2 !== 32'd0) begin bad++; $display("FAIL reset_rd2 got=%h exp=0", read_data_2); end
    total++; if (OpCode !== 4'd0) begin bad++; $display("FAIL reset_opcode got=%h exp=0", OpCode); end
    total++; if (ex_rd_addr !== 5'd0) begin bad++; $display("FAIL reset_rd_addr got=%h exp=0", ex_rd_addr); end
    total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL reset_reg_write got=%b exp=0", ex_reg_write); end
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL reset_dec_ready got=%b exp=1", dec_ready); end
    rst_n = 1;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2;
    logic [3:0]  eop;
    logic [4:0]  erd;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_dec(5'(1 + i), 32'd5 + 32'(i * 16), 5'(11 + i), 32'd7 + 32'(i * 16),
              5'(20 + i), 32'd0, 1'b0, 4'(4 + i), 1'b1);
      e1 = 32'd5 + 32'(i * 16); e2 = 32'd7 + 32'(i * 16);
      eop = 4'(4 + i); erd = 5'(20 + i);
      @(negedge clk);
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL b2b_dec_ready[%0d] got=%b exp=1", i, dec_ready); end
      @(posedge clk); #1;
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, ex_valid); end
      total++; if (read_data_1 !== e1) begin bad++; $display("FAIL b2b_rd1[%0d] got=%h exp=%h", i, read_data_1, e1); end
      total++; if (read_data_2 !== e2) begin bad++; $display("FAIL b2b_rd2[%0d] got=%h exp=%h", i, read_data_2, e2); end
      total++; if (OpCode !== eop) begin bad++; $display("FAIL b2b_opcode[%0d] got=%h exp=%h", i, OpCode, eop); end
      total++; if (ex_rd_addr !== erd) begin bad++; $display("FAIL b2b_rd_addr[%0d] got=%h exp=%h", i, ex_rd_addr, erd); end
      total++; if (ex_reg_write !== 1'b1) begin bad++; $display("FAIL b2b_reg_write[%0d] got=%b exp=1", i, ex_reg_write); end
    end
    dec_valid = 0;
    @(posedge clk); #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", ex_valid); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL b2b_stall got=%h exp=0", stall_cycles); end
  endtask

  task automatic test_forward();
    do_reset();
    set_dec(5'd3, 32'h11, 5'd4, 32'h22, 5'd9, 32'd0, 1'b0, 4'h2, 1'b1);
    @(posedge clk); #1;
    dec_valid = 0;
    exmem_rd = 3; exmem_reg_write = 1; exmem_data = 32'hAA;
    memwb_rd = 3; memwb_reg_write = 1; memwb_data = 32'hBB;
    #1;
    total++; if (read_data_1 !== 32'hAA) begin bad++; $display("FAIL fwd_exmem_wins got=%h exp=000000aa", read_data_1); end
    total++; if (read_data_2 !== 32'h22) begin bad++; $display("FAIL fwd_rs2_stored got=%h exp=00000022", read_data_2); end
    exmem_reg_write = 0;
    #1;
    total++; if (read_data_1 !== 32'hBB) begin bad++; $display("FAIL fwd_memwb got=%h exp=000000bb", read_data_1); end
    exmem_rd = 4; exmem_reg_write = 1;
    #1;
    total++; if (read_data_2 !== 32'hAA) begin bad++; $display("FAIL fwd_rs2_exmem got=%h exp=000000aa", read_data_2); end
    total++; if (read_data_1 !== 32'hBB) begin bad++; $display("FAIL fwd_rs1_memwb_kept got=%h exp=000000bb", read_data_1); end
    exmem_reg_write = 0; memwb_reg_write = 0;
    set_dec(5'd0, 32'd0, 5'd4, 32'h22, 5'd9, 32'd0, 1'b0, 4'h2, 1'b1);
    @(posedge clk); #1;
    dec_valid = 0;
    exmem_rd = 0; exmem_reg_write = 1; exmem_data = 32'hAA;
    memwb_rd = 0; memwb_reg_write = 1; memwb_data = 32'hBB;
    #1;
    total++; if (read_data_1 !== 32'd0) begin bad++; $display("FAIL fwd_x0 got=%h exp=0", read_data_1); end
    idle_inputs();
  endtask

  task automatic test_stall_refresh();
    do_reset();
    set_dec(5'd1, 32'h10, 5'd2, 32'h20, 5'd5, 32'd0, 1'b0, 4'h3, 1'b1);
    @(posedge clk); #1;
    dec_valid = 0; ex_ready = 0;
    memwb_rd = 2; memwb_reg_write = 1; memwb_data = 32'h1234;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++; if (read_data_2 !== 32'h1234) begin bad++; $display("FAIL stall_rd2[%0d] got=%h exp=00001234", c, read_data_2); end
      total++; if (read_data_1 !== 32'h10) begin bad++; $display("FAIL stall_rd1[%0d] got=%h exp=00000010", c, read_data_1); end
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL stall_dec_ready[%0d] got=%b exp=0", c, dec_ready); end
      @(posedge clk); #1;
      memwb_reg_write = 0; memwb_data = 32'hDEAD;
    end
    total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL stall_count got=%h exp=3", stall_cycles); end
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL stall_valid_held got=%b exp=1", ex_valid); end
    ex_ready = 1;
    @(posedge clk); #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b exp=0", ex_valid); end
    total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL stall_count_after got=%h exp=3", stall_cycles); end
  endtask

  task automatic test_imm();
    do_reset();
    set_dec(5'd1, 32'h10, 5'd6, 32'h66, 5'd7, 32'hFFFF_FFF0, 1'b1, 4'hF, 1'b1);
    @(posedge clk); #1;
    dec_valid = 0;
    exmem_rd = 6; exmem_reg_write = 1; exmem_data = 32'h99;
    @(negedge clk);
    total++; if (read_data_2 !== 32'hFFFF_FFF0) begin bad++; $display("FAIL imm_select got=%h exp=fffffff0", read_data_2); end
    total++; if (OpCode !== 4'hF) begin bad++; $display("FAIL imm_opcode_passthru got=%h exp=f", OpCode); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    set_dec(5'd1, 32'h10, 5'd2, 32'h20, 5'd8, 32'd0, 1'b0, 4'h1, 1'b1);
    @(posedge clk); #1;
    set_dec(5'd3, 32'h30, 5'd4, 32'h40, 5'd9, 32'd0, 1'b0, 4'h2, 1'b1);
    flush = 1; ex_ready = 1;
    @(negedge clk);
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL flush_dec_ready got=%b exp=1", dec_ready); end
    @(posedge clk); #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", ex_valid); end
    total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL flush_reg_write got=%b exp=0", ex_reg_write); end
    flush = 0;
    @(posedge clk); #1;
    dec_valid = 0; flush = 1; ex_ready = 0;
    @(posedge clk); #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_stalled_valid got=%b exp=0", ex_valid); end
    total++; if (stall_cycles !== 32'd1) begin bad++; $display("FAIL flush_stall_count got=%h exp=1", stall_cycles); end
    idle_inputs();
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    set_dec(5'd1, 32'h10, 5'd2, 32'h20, 5'd8, 32'd0, 1'b0, 4'h1, 1'b1);
    @(posedge clk); #1;
    dec_valid = 0; ex_ready = 0;
    force dut.r_stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cycles;
    #1;
    total++; if (stall_cycles !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sat_preload got=%h exp=fffffffd", stall_cycles); end
    @(posedge clk); #1;
    total++; if (stall_cycles !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sat_step1 got=%h exp=fffffffe", stall_cycles); end
    @(posedge clk); #1;
    total++; if (stall_cycles !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_step2 got=%h exp=ffffffff", stall_cycles); end
    @(posedge clk); #1;
    total++; if (stall_cycles !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffffffff", stall_cycles); end
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL sat_valid_held got=%b exp=1", ex_valid); end
    rst_n = 0;
    @(posedge clk); #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_stall_valid got=%b exp=0", ex_valid); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_mid_stall_count got=%h exp=0", stall_cycles); end
    total++; if (read_data_1 !== 32'd0) begin bad++; $display("FAIL rst_mid_stall_rd1 got=%h exp=0", read_data_1); end
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_stall_dec_ready got=%b exp=1", dec_ready); end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    #2;
    test_reset();
    test_back_to_back();
    test_forward();
    test_stall_refresh();
    test_imm();
    test_flush();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
